riscv_decode: RTL

- Decode stage directly downstream of the fetch unit in the RV32I core.
- Accepts one 32-bit instruction word plus its PC per handshake.
- Splits the instruction into register indices, a sign-extended immediate, an ALU operation code and instruction-class flags.
- Holds the result in a single-entry pipeline register that feeds execute/control through a valid/ready handshake.

---
 rtl/riscv_decode.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_decode.sv
// riscv_decode: RV32I decode stage sitting directly after fetch.
//
// Takes one instruction word plus its PC per handshake, splits it into
// register indices, a sign-extended immediate, an ALU operation code and
// instruction-class flags, and holds the result in a single-entry pipeline
// register that feeds execute/control.
//
// Ports
//   clk, reset          core clock; asynchronous active-low reset
//   flush_i             drop the held entry and any instruction offered now
//   instr_valid_i/_ready_o, instr_i, pc_i   upstream (fetch) handshake
//   out_valid_o/out_ready_i                 downstream handshake
//   pc_o, rd_o, rs1_o, rs2_o, funct3_o, imm_o, alu_op_o, alu_src_imm_o,
//   reg_we_o, is_*_o, illegal_o             registered decode results
//
// Handshake: a beat moves on a rising edge when valid && ready are both 1
// in the cycle before that edge. valid never depends on ready; once
// out_valid_o is raised the entry and all its fields stay frozen until it
// is consumed (out_ready_i=1), flushed, or reset. instr_ready_o is
// combinational: the entry slot is free when empty or draining this cycle.

module riscv_decode #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rd_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [2:0]      funct3_o,
  output logic [31:0]     imm_o,
  output logic [3:0]      alu_op_o,
  output logic            alu_src_imm_o,
  output logic            reg_we_o,
  output logic            is_load_o,
  output logic            is_store_o,
  output logic            is_branch_o,
  output logic            is_jal_o,
  output logic            is_jalr_o,
  output logic            is_lui_o,
  output logic            is_auipc_o,
  output logic            illegal_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // funct3 -> base ALU op; the SUB/SRA alternates are applied by the caller
  function automatic logic [3:0] alu_base(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_base = 4'd0;  // ADD
      3'b001:  alu_base = 4'd2;  // SLL
      3'b010:  alu_base = 4'd3;  // SLT
      3'b011:  alu_base = 4'd4;  // SLTU
      3'b100:  alu_base = 4'd5;  // XOR
      3'b101:  alu_base = 4'd6;  // SRL
      3'b110:  alu_base = 4'd8;  // OR
      default: alu_base = 4'd9;  // AND
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];

  // Combinational decode of the offered word
  logic [31:0] imm_d;
  logic [3:0]  alu_op_d;
  logic        src_imm_d, we_d, illegal_d;
  logic        load_d, store_d, branch_d, jal_d, jalr_d, lui_d, auipc_d;

  always_comb begin
    imm_d     = '0;
    alu_op_d  = ALU_ADD;
    src_imm_d = 1'b1;
    we_d      = 1'b0;
    illegal_d = 1'b0;
    load_d    = 1'b0;
    store_d   = 1'b0;
    branch_d  = 1'b0;
    jal_d     = 1'b0;
    jalr_d    = 1'b0;
    lui_d     = 1'b0;
    auipc_d   = 1'b0;
    case (opcode)
      OPC_OP: begin
        src_imm_d = 1'b0;
        we_d      = 1'b1;
        alu_op_d  = alu_base(f3);
        if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      alu_op_d = ALU_SUB;
          else if (f3 == 3'b101) alu_op_d = ALU_SRA;
          else                   illegal_d = 1'b1;
        end else if (f7 != 7'b0000000) begin
          illegal_d = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        imm_d    = {{20{instr_i[31]}}, instr_i[31:20]};
        we_d     = 1'b1;
        alu_op_d = alu_base(f3);
        // funct7 only means something for the shift forms
        if (f3 == 3'b001 && f7 != 7'b0000000) illegal_d = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == 7'b0100000)      alu_op_d  = ALU_SRA;
          else if (f7 != 7'b0000000) illegal_d = 1'b1;
        end
      end
      OPC_LOAD: begin
        imm_d     = {{20{instr_i[31]}}, instr_i[31:20]};
        we_d      = 1'b1;
        load_d    = 1'b1;
        illegal_d = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        imm_d     = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        store_d   = 1'b1;
        illegal_d = (f3 > 3'b010);
      end
      OPC_BRANCH: begin
        imm_d     = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                     instr_i[30:25], instr_i[11:8], 1'b0};
        alu_op_d  = ALU_SUB;
        src_imm_d = 1'b0;
        branch_d  = 1'b1;
        illegal_d = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_JAL: begin
        imm_d = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                 instr_i[20], instr_i[30:21], 1'b0};
        we_d  = 1'b1;
        jal_d = 1'b1;
      end
      OPC_JALR: begin
        imm_d     = {{20{instr_i[31]}}, instr_i[31:20]};
        we_d      = 1'b1;
        jalr_d    = 1'b1;
        illegal_d = (f3 != 3'b000);
      end
      OPC_LUI: begin
        imm_d    = {instr_i[31:12], 12'b0};
        alu_op_d = ALU_PASSB;
        we_d     = 1'b1;
        lui_d    = 1'b1;
      end
      OPC_AUIPC: begin
        imm_d   = {instr_i[31:12], 12'b0};
        we_d    = 1'b1;
        auipc_d = 1'b1;
      end
      default: illegal_d = 1'b1;
    endcase

    if (instr_i[1:0] != 2'b11) illegal_d = 1'b1;

    // An illegal entry still flows so control can trap, but it must not
    // look like any class nor write the register file.
    if (illegal_d) begin
      we_d     = 1'b0;
      load_d   = 1'b0;
      store_d  = 1'b0;
      branch_d = 1'b0;
      jal_d    = 1'b0;
      jalr_d   = 1'b0;
      lui_d    = 1'b0;
      auipc_d  = 1'b0;
    end
    if (instr_i[11:7] == 5'd0) we_d = 1'b0;
  end

  // Entry register
  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic [2:0]      f3_q;
  logic [31:0]     imm_q;
  logic [3:0]      alu_op_q;
  logic            src_imm_q, we_q, illegal_q;
  logic            load_q, store_q, branch_q, jal_q, jalr_q, lui_q, auipc_q;
  logic            accept;

  assign instr_ready_o = !valid_q || out_ready_i;
  assign accept        = instr_valid_i && instr_ready_o;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      pc_q      <= RESET_PC_TAG;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      f3_q      <= '0;
      imm_q     <= '0;
      alu_op_q  <= '0;
      src_imm_q <= 1'b0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
      load_q    <= 1'b0;
      store_q   <= 1'b0;
      branch_q  <= 1'b0;
      jal_q     <= 1'b0;
      jalr_q    <= 1'b0;
      lui_q     <= 1'b0;
      auipc_q   <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;  // beats both consume and accept
    end else if (accept) begin
      valid_q   <= 1'b1;
      pc_q      <= pc_i;
      rd_q      <= instr_i[11:7];
      rs1_q     <= instr_i[19:15];
      rs2_q     <= instr_i[24:20];
      f3_q      <= f3;
      imm_q     <= imm_d;
      alu_op_q  <= alu_op_d;
      src_imm_q <= src_imm_d;
      we_q      <= we_d;
      illegal_q <= illegal_d;
      load_q    <= load_d;
      store_q   <= store_d;
      branch_q  <= branch_d;
      jal_q     <= jal_d;
      jalr_q    <= jalr_d;
      lui_q     <= lui_d;
      auipc_q   <= auipc_d;
    end else if (valid_q && out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o   = valid_q;
  assign pc_o          = pc_q;
  assign rd_o          = rd_q;
  assign rs1_o         = rs1_q;
  assign rs2_o         = rs2_q;
  assign funct3_o      = f3_q;
  assign imm_o         = imm_q;
  assign alu_op_o      = alu_op_q;
  assign alu_src_imm_o = src_imm_q;
  assign reg_we_o      = we_q;
  assign illegal_o     = illegal_q;
  assign is_load_o     = load_q;
  assign is_store_o    = store_q;
  assign is_branch_o   = branch_q;
  assign is_jal_o      = jal_q;
  assign is_jalr_o     = jalr_q;
  assign is_lui_o      = lui_q;
  assign is_auipc_o    = auipc_q;

endmodule
